example: RTL and testbench
==========================

# example

Pair-array selector. The block takes a 32-bit word that holds a 2×2 packed array of 8-bit pairs. Each pair has a 4-bit `x` and a 4-bit `y`. Two index bits pick one pair, and the block drives its `x` and `y` fields onto registered outputs. It is a small datapath leaf, used wherever a packed struct-of-struct word must be split into its fields by runtime index.

## Interface
- No parameters. Widths are fixed: 4-bit fields, 8-bit pair, 2×2 array, 32-bit word.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `data`  input  32  packed pair array `[1:0][1:0]`.
- `p1`  input  1  outer (major) index.
- `p2`  input  1  inner (minor) index.
- `out_x`  output  4  `x` field of the selected pair.
- `out_y`  output  4  `y` field of the selected pair.

## Operation
- Pair layout:
  - Each pair is 8 bits, with `x` in bits [7:4] (MSB side) and `y` in bits [3:0].
  - Array element `data[i][j]` occupies bits [8k+7 : 8k], where k = 2·i + j.
  - Element [1][1] is in [31:24]; element [0][0] is in [7:0].
- Selection:
  - k = {p1, p2}.
  - `out_x` = `data`[8k+7 : 8k+4].
  - `out_y` = `data`[8k+3 : 8k].
- Pure selection: no arithmetic, no sign handling, no width changes.
- All 32 bits of `data` are reachable; no index value is illegal.

## Timing
- Outputs are registered: there is 1 cycle from `data`/`p1`/`p2` sampled at rising edge N to the new `out_x`/`out_y` after edge N.
- No handshake. A new selection is accepted every cycle.
- Reset:
  - `rst_n` low clears `out_x` and `out_y` to 4'h0 immediately, without waiting for a clock edge.
  - Outputs stay 0 while `rst_n` is low.
  - The first capture happens at the first rising edge after `rst_n` deasserts.
- If `data` and the index change in the same cycle, the output reflects both new values together. No mixing of old and new values is allowed.
- If reset asserts mid-stream, the in-flight selection is discarded.

## Configuration
- `EXAMPLE_INPUT_REG_EN`:
  - When defined, `data`, `p1` and `p2` are registered before selection, giving a total latency of 2 cycles. The input registers reset to 0 asynchronously on `rst_n` low.
  - When undefined, only the output registers exist and latency is 1 cycle.
- The reset value of the outputs is 0 in both modes.

## Structure
- Shared package `example_pkg` holds:
  - `pair_t`, a packed struct with `logic [3:0] x` followed by `logic [3:0] y`.
  - `pair_arr_t`, defined as `pair_t [1:0][1:0]`, 32 bits.
  - Localparams for the field width (4) and pair width (8).
- `data` is declared or cast as `pair_arr_t`, and selection is written as `data[p1][p2].x` and `data[p1][p2].y`.
- One sub-module, `pair_select`, is natural. It is combinational: it takes the array and the two index bits and returns a `pair_t`. The top level instantiates it and adds the registers.

## Test plan
Outputs are checked one cycle after the inputs are applied, or two cycles when `EXAMPLE_INPUT_REG_EN` is defined.
- Reset: hold `rst_n`=0 with `data`=32'hA7107338 → `out_x`=0 and `out_y`=0, with no clock edge needed. Release reset → outputs reach the selected values after the configured latency.
- `data`=32'hA7107338, sweep (p1,p2) through (0,0), (0,1), (1,0), (1,1) → `out_x`/`out_y` = 3/8, 7/3, 1/0, A/7.
- `data`=32'h8F8259E4, same sweep → E/4, 5/9, 8/2, 8/F.
- `data`=32'hBF93017E, same sweep → 7/E, 0/1, 9/3, B/F.
- Change `data` from 32'h80AD046A to 32'hE6458A2D in the same cycle as (p1,p2) changes from (0,0) to (1,1) → the output goes from 6/A directly to E/6, with no intermediate value. Also assert `rst_n` for one cycle mid-sweep → outputs go to 0 asynchronously, then recover.

Source files
------------

// File: rtl/example_pkg.sv
// Shared types for the pair-array selector: 4-bit x/y pairs packed 2x2 into a 32-bit word.
package example_pkg;

  localparam int FIELD_W = 4;
  localparam int PAIR_W  = 2 * FIELD_W;
  localparam int WORD_W  = 4 * PAIR_W;

  typedef struct packed {
    logic [FIELD_W-1:0] x;
    logic [FIELD_W-1:0] y;
  } pair_t;

  typedef pair_t [1:0][1:0] pair_arr_t;

endpackage

// File: rtl/example_pair_select.sv
// Combinational pick of one pair from a 2x2 packed pair array by outer/inner index.
module pair_select
  import example_pkg::*;
(
  input  pair_arr_t arr_i,
  input  logic      p1_i,
  input  logic      p2_i,
  output pair_t     pair_o
);

  assign pair_o = arr_i[p1_i][p2_i];

endmodule

// File: rtl/example.sv
// Pair-array selector top: selects data[p1][p2] and registers its x/y fields.
// Optional EXAMPLE_INPUT_REG_EN adds an input register stage (2-cycle latency).
module example
  import example_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] data,
  input  logic              p1,
  input  logic              p2,
  output logic [FIELD_W-1:0] out_x,
  output logic [FIELD_W-1:0] out_y
);

  pair_arr_t sel_arr;
  logic      sel_p1;
  logic      sel_p2;
  pair_t     pair_d;
  pair_t     pair_q;

`ifdef EXAMPLE_INPUT_REG_EN
  pair_arr_t data_q;
  logic      p1_q;
  logic      p2_q;

  // Word and indices are captured together so a selection never mixes old and new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      p1_q   <= 1'b0;
      p2_q   <= 1'b0;
    end else begin
      data_q <= pair_arr_t'(data);
      p1_q   <= p1;
      p2_q   <= p2;
    end
  end

  assign sel_arr = data_q;
  assign sel_p1  = p1_q;
  assign sel_p2  = p2_q;
`else
  assign sel_arr = pair_arr_t'(data);
  assign sel_p1  = p1;
  assign sel_p2  = p2;
`endif

  pair_select u_pair_select (
    .arr_i  (sel_arr),
    .p1_i   (sel_p1),
    .p2_i   (sel_p2),
    .pair_o (pair_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
    end else begin
      pair_q <= pair_d;
    end
  end

  assign out_x = pair_q.x;
  assign out_y = pair_q.y;

endmodule

// File: tb/tb_example.sv
// Scoreboard bench for the pair-array selector; latency follows EXAMPLE_INPUT_REG_EN.
module tb_example;

`ifdef EXAMPLE_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic        p1;
  logic        p2;
  logic [3:0]  out_x;
  logic [3:0]  out_y;

  int n_checks;
  int n_errors;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  example dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .p1    (p1),
    .p2    (p2),
    .out_x (out_x),
    .out_y (out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got x/y=%h/%h expected x/y=%h/%h", tag, act[7:4], act[3:0], exp[7:4], exp[3:0]);
    end
  endtask

  // Drive one selection per cycle; compare outputs once the pipeline holds LAT entries.
  task automatic step(input string tag, input logic [31:0] d, input logic a, input logic b,
                      input logic [7:0] exp);
    @(negedge clk);
    while (exp_q.size() >= LAT) begin
      check_val(tag_q.pop_front(), {out_x, out_y}, exp_q.pop_front());
    end
    data = d;
    p1   = a;
    p2   = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    repeat (LAT) begin
      @(negedge clk);
      if (exp_q.size() > 0) check_val(tag_q.pop_front(), {out_x, out_y}, exp_q.pop_front());
    end
  endtask

  task automatic sweep(input string tag, input logic [31:0] d, input logic [31:0] exp_word);
    logic [31:0] e;
    e = exp_word;
    step({tag, "_00"}, d, 1'b0, 1'b0, e[7:0]);
    step({tag, "_01"}, d, 1'b0, 1'b1, e[15:8]);
    step({tag, "_10"}, d, 1'b1, 1'b0, e[23:16]);
    step({tag, "_11"}, d, 1'b1, 1'b1, e[31:24]);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    data  = 32'hA7107338;
    p1    = 1'b0;
    p2    = 1'b0;

    // Before the first clock edge: reset alone must hold outputs at zero.
    #2;
    check_val("rst_no_edge", {out_x, out_y}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check_val("rst_held", {out_x, out_y}, 8'h00);
    rst_n = 1'b1;

    sweep("w0", 32'hA7107338, {8'hA7, 8'h10, 8'h73, 8'h38});
    sweep("w1", 32'h8F8259E4, {8'h8F, 8'h82, 8'h59, 8'hE4});
    sweep("w2", 32'hBF93017E, {8'hBF, 8'h93, 8'h01, 8'h7E});

    // Word and index change together: 6/A straight to E/6.
    step("same_a", 32'h80AD046A, 1'b0, 1'b0, 8'h6A);
    step("same_a2", 32'h80AD046A, 1'b0, 1'b0, 8'h6A);
    step("same_b", 32'hE6458A2D, 1'b1, 1'b1, 8'hE6);
    step("same_b2", 32'hE6458A2D, 1'b1, 1'b1, 8'hE6);
    drain();

    // Mid-sweep reset pulse: outputs clear asynchronously, in-flight selections dropped.
    step("pre_rst_00", 32'hA7107338, 1'b0, 1'b1, 8'h73);
    step("pre_rst_01", 32'hA7107338, 1'b1, 1'b0, 8'h10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_async", {out_x, out_y}, 8'h00);
    exp_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1;
    check_val("rst_mid_hold", {out_x, out_y}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    sweep("rec", 32'h8F8259E4, {8'h8F, 8'h82, 8'h59, 8'hE4});
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no summary expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
